instr_encoder_loader: RTL and testbench

- Encoder counterpart to the instruction decoder.
- Accepts instruction fields (OP_CODE, MEM_OP, OPERAND) over a valid/ready stream and packs them into the 16-bit instruction format.
- Writes each word into program memory at auto-incrementing addresses from a programmable base.
- Sits between the host/boot interface and program memory; used for program loading before CPU execution.

---
 rtl/instr_encoder_loader.sv | 143 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs instruction fields into the 16-bit instruction word
//   {op_code, mem_op, operand} and writes each word to program memory at
//   auto-incrementing addresses starting from a base sampled on START.
//   It sits between the host/boot interface and program memory and is used
//   to load a program before the CPU starts executing it.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, abort      session control (abort has priority over start)
//   base_addr         first write address, sampled when START is accepted
//   in_valid/in_ready field-set stream handshake
//   in_op_code        ALU operation code           -> word[15:12]
//   in_mem_op         memory operation code        -> word[11:8]
//   in_operand        left [7:4] / right [3:0]     -> word[7:0]
//   in_last           final instruction of the session
//   pm_we/pm_ready    program memory write request / acknowledge
//   pm_addr, pm_wdata write address and encoded instruction
//   busy              session active (LOAD or WRITE)
//   done              one-cycle pulse on normal completion
//   error             overflow flag, held until the next START or ABORT
//   word_count        words written in the current or last session
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op_code,
  input  logic [3:0]            in_mem_op,
  input  logic [7:0]            in_operand,
  input  logic                  in_last,
  output logic                  pm_we,
  input  logic                  pm_ready,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [15:0]           pm_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MAX_WORDS);

  logic [2:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [15:0]           wdata_reg;
  logic                  last_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_inc;
  logic                  pm_we_reg;
  logic                  done_reg;
  logic                  error_reg;
  logic                  accept;
  logic                  wr_ack;
  logic                  start_ok;

  assign in_ready = (state_reg == S_LOAD);
  assign busy     = (state_reg == S_LOAD) || (state_reg == S_WRITE);

  assign accept    = (state_reg == S_LOAD) && in_valid;
  // pm_ready outside WRITE is simply never looked at.
  assign wr_ack    = (state_reg == S_WRITE) && pm_ready;
  assign start_ok  = start && ((state_reg == S_IDLE) || (state_reg == S_ERR));
  assign count_inc = count_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (start) state_next = S_LOAD;
        S_LOAD:  if (in_valid) state_next = S_WRITE;
        S_WRITE: begin
          if (pm_ready) begin
            // A last word landing exactly on the limit still completes normally.
            if (last_reg)                  state_next = S_DONE;
            else if (count_inc == MAX_CNT) state_next = S_ERR;
            else                           state_next = S_LOAD;
          end
        end
        S_DONE:  state_next = S_IDLE;
        S_ERR:   if (start) state_next = S_LOAD;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      last_reg  <= 1'b0;
      count_reg <= '0;
      pm_we_reg <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Flag outputs are registered copies of the state being entered, so
      // they line up with the state itself with no extra cycle of delay.
      pm_we_reg <= (state_next == S_WRITE);
      done_reg  <= (state_next == S_DONE);
      error_reg <= (state_next == S_ERR);
      // Abort discards everything, including a write acknowledged this cycle.
      if (!abort) begin
        if (start_ok) begin
          addr_reg  <= base_addr;
          count_reg <= '0;
        end
        if (accept) begin
          wdata_reg <= {in_op_code, in_mem_op, in_operand};
          last_reg  <= in_last;
        end
        if (wr_ack) begin
          addr_reg  <= addr_reg + 1'b1;
          count_reg <= count_inc;
        end
      end
    end
  end

  assign pm_we      = pm_we_reg;
  assign pm_addr    = addr_reg;
  assign pm_wdata   = wdata_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int AW   = 8;
  localparam int MAXW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op_code;
  logic [3:0]    in_mem_op;
  logic [7:0]    in_operand;
  logic          in_last;
  logic          pm_we;
  logic          pm_ready;
  logic [AW-1:0] pm_addr;
  logic [15:0]   pm_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;

  // Field sets for the next session, as whole instruction words.
  logic [15:0] fld [8];

  instr_encoder_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op_code(in_op_code),
    .in_mem_op(in_mem_op), .in_operand(in_operand), .in_last(in_last),
    .pm_we(pm_we), .pm_ready(pm_ready), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_field(input logic [15:0] w, input logic last);
    in_valid   = 1'b1;
    in_op_code = w[15:12];
    in_mem_op  = w[11:8];
    in_operand = w[7:0];
    in_last    = last;
  endtask

  task automatic idle_field();
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_op_code = 4'($urandom);
    in_mem_op  = 4'($urandom);
    in_operand = 8'($urandom);
  endtask

  // One load session. Expected outcome from the loading rules:
  //  - a last flag within the first MAXW words -> that many writes, then DONE
  //  - otherwise, if MAXW words are offered -> MAXW writes, then overflow
  //  - otherwise the session idles in LOAD and is aborted here.
  // Word i goes to (base + i) mod 256 with data fld[i].
  task automatic run_session(input logic [7:0] base, input int nfields, input int lastpos,
                             input int stall_len, input bit abort_tail);
    int exp_words;
    int outcome;  // 0 done, 1 overflow, 2 left in load
    logic [7:0] ea;
    if (lastpos >= 0 && lastpos < MAXW) begin
      exp_words = lastpos + 1; outcome = 0;
    end else if (nfields >= MAXW) begin
      exp_words = MAXW; outcome = 1;
    end else begin
      exp_words = nfields; outcome = 2;
    end

    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0; base_addr = 8'($urandom);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    chk("start_count", word_count, 0);
    chk("start_error_clear", error, 0);

    for (int i = 0; i < exp_words; i++) begin
      ea = base + 8'(i);
      drive_field(fld[i], i == lastpos);
      pm_ready = (i == 0 && stall_len > 0) ? 1'b0 : 1'b1;
      tick();
      idle_field();
      chk("we_latency", pm_we, 1);
      chk("wr_addr", pm_addr, ea);
      chk("wr_data", pm_wdata, fld[i]);
      chk("wr_in_ready", in_ready, 0);
      if (i == 0) begin
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk("stall_we", pm_we, 1);
          chk("stall_addr", pm_addr, ea);
          chk("stall_data", pm_wdata, fld[i]);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_count", word_count, 0);
        end
      end
      pm_ready = 1'b1;
      tick();
      chk("ack_count", word_count, i + 1);
      if (outcome == 0 && i == exp_words - 1) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_error", error, 0);
        tick();
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);
        chk("done_count_hold", word_count, exp_words);
      end else if (outcome == 1 && i + 1 == MAXW) begin
        chk("ovf_error", error, 1);
        chk("ovf_in_ready", in_ready, 0);
        chk("ovf_we", pm_we, 0);
        chk("ovf_no_done", done, 0);
      end else begin
        chk("back_in_ready", in_ready, 1);
        chk("back_we", pm_we, 0);
        chk("back_done", done, 0);
      end
    end

    if (outcome == 1) begin
      // Offer the extra field: it must not be taken while in error.
      drive_field(fld[MAXW], lastpos == MAXW);
      tick();
      tick();
      idle_field();
      chk("err_hold", error, 1);
      chk("err_no_we", pm_we, 0);
      chk("err_no_done", done, 0);
      chk("err_count", word_count, MAXW);
      if (abort_tail) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_clears_err", error, 0);
        chk("abort_err_busy", busy, 0);
      end
    end else if (outcome == 2) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_load_busy", busy, 0);
      chk("abort_load_count", word_count, exp_words);
      chk("abort_load_done", done, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_op_code = '0; in_mem_op = '0; in_operand = '0;
    in_last = 1'b0; pm_ready = 1'b1;
    tick(); tick();
    chk("rst_we", pm_we, 0);
    chk("rst_addr", pm_addr, 0);
    chk("rst_data", pm_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_count", word_count, 0);
    rst = 1'b0;
    tick();

    // Basic load.
    fld[0] = 16'h31A5; fld[1] = 16'hF000;
    run_session(8'h10, 2, 1, 0, 1'b0);

    // Memory backpressure on the first write.
    fld[0] = 16'h1234; fld[1] = 16'hABCD;
    run_session(8'h20, 2, 1, 3, 1'b0);

    // Overflow, stay in error, then restart at a new base.
    for (int i = 0; i < 5; i++) fld[i] = 16'(16'h5000 + i);
    run_session(8'h40, 5, 4, 0, 1'b0);
    fld[0] = 16'h7E81;
    run_session(8'h80, 1, 0, 0, 1'b0);

    // Address wrap.
    fld[0] = 16'h2222; fld[1] = 16'h3333;
    run_session(8'hFF, 2, 1, 0, 1'b0);

    // Abort during an unacknowledged write after one completed write.
    start = 1'b1; base_addr = 8'h60;
    tick();
    start = 1'b0;
    drive_field(16'hAAAA, 1'b0);
    tick();
    idle_field();
    tick();  // acknowledged with pm_ready=1
    chk("abort_pre_count", word_count, 1);
    drive_field(16'hBBBB, 1'b0);
    pm_ready = 1'b0;
    tick();
    idle_field();
    chk("abort_pre_we", pm_we, 1);
    chk("abort_pre_addr", pm_addr, 8'h61);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_we_drop", pm_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", word_count, 1);
    chk("abort_no_done", done, 0);
    pm_ready = 1'b1;
    tick();
    chk("abort_stays_idle", busy, 0);
    chk("abort_no_write", pm_we, 0);

    // START together with ABORT from IDLE.
    start = 1'b1; abort = 1'b1; base_addr = 8'h70;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_ready", in_ready, 0);

    // START while loading is ignored.
    start = 1'b1; base_addr = 8'h90;
    tick();
    start = 1'b1; base_addr = 8'h55;
    drive_field(16'hC0DE, 1'b1);
    tick();
    start = 1'b0;
    idle_field();
    chk("start_ignored_addr", pm_addr, 8'h90);
    chk("start_ignored_data", pm_wdata, 16'hC0DE);
    tick();
    chk("start_ignored_done", done, 1);
    chk("start_ignored_count", word_count, 1);
    tick();

    // Asynchronous reset in the middle of a write.
    start = 1'b1; base_addr = 8'h33;
    tick();
    start = 1'b0;
    drive_field(16'h9999, 1'b0);
    pm_ready = 1'b0;
    tick();
    idle_field();
    chk("prereset_we", pm_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", pm_we, 0);
    chk("arst_addr", pm_addr, 0);
    chk("arst_data", pm_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_count", word_count, 0);
    tick();
    rst = 1'b0; pm_ready = 1'b1;
    tick();
    fld[0] = 16'h4321; fld[1] = 16'h8765;
    run_session(8'h34, 2, 1, 0, 1'b0);

    // Randomized sessions.
    for (int k = 0; k < 25; k++) begin
      int n;
      int r;
      int lp;
      n = $urandom_range(1, 6);
      r = $urandom_range(0, n);
      lp = (r == n) ? -1 : r;
      for (int i = 0; i < 8; i++) fld[i] = 16'($urandom);
      run_session(8'($urandom), n, lp, $urandom_range(0, 3), 1'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
